// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among N requesters
module fifo_wr_arbiter #(
    parameter int N = 4,
    parameter int DW = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*DW-1:0]      req_data,
    input  logic [N-1:0]         req_last,
    input  logic                 fifo_full,
    output logic [N-1:0]         gnt,
    output logic [N-1:0]         ack,
    output logic                 wr_en,
    output logic [DW-1:0]        wr_data,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy
);
    localparam int OW = $clog2(N);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state, state_n;
    logic [N-1:0]  gnt_n;
    logic [OW-1:0] owner_n, rr_ptr, rr_n, pick, nxt_ptr;
    logic [CW-1:0] cnt, cnt_n;
    logic          xfer, done;

    assign busy    = (state == BURST);
    assign xfer    = busy & req[owner] & ~fifo_full & rst;
    assign wr_en   = xfer;
    assign ack     = xfer ? N'(1) << owner : '0;
    assign wr_data = req_data[owner*DW +: DW];
    assign done    = ~req[owner] | (xfer & (req_last[owner] | (int'(cnt) + 1 == MAX_BURST)));
    assign nxt_ptr = (int'(owner) == N - 1) ? '0 : owner + 1'b1;

    always_comb begin
        pick = rr_ptr;
        for (int k = N - 1; k >= 0; k--)
            if (req[(int'(rr_ptr) + k) % N]) pick = OW'((int'(rr_ptr) + k) % N);
    end

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        owner_n = owner;
        rr_n    = rr_ptr;
        cnt_n   = cnt;
        if (state == IDLE) begin
            if (|req) begin
                state_n = BURST;
                owner_n = pick;
                gnt_n   = N'(1) << pick;
                cnt_n   = '0;
            end
        end else if (done) begin
            state_n = IDLE;
            gnt_n   = '0;
            rr_n    = nxt_ptr;
        end else if (xfer) begin
            cnt_n = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            gnt    <= '0;
            owner  <= '0;
            rr_ptr <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_n;
            gnt    <= gnt_n;
            owner  <= owner_n;
            rr_ptr <= rr_n;
            cnt    <= cnt_n;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: table vectors, directed corner sequences and a random run against a reference model
module tb_fifo_wr_arbiter;
    localparam int N = 4;
    localparam int DW = 8;
    localparam int MB = 16;

    logic          clk = 0;
    logic          rst, fifo_full, wr_en, busy;
    logic [N-1:0]  req, req_last, gnt, ack;
    logic [N*DW-1:0] req_data;
    logic [DW-1:0] wr_data;
    logic [1:0]    owner;

    int n_vec = 0;
    int n_err = 0;

    fifo_wr_arbiter #(.N(N), .DW(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
        .fifo_full(fifo_full), .gnt(gnt), .ack(ack), .wr_en(wr_en), .wr_data(wr_data),
        .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] r;
        logic [N-1:0] l;
        logic         f;
        logic [N-1:0] g;
        logic         w;
        logic [N-1:0] a;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 0; req = '0; req_last = '0; fifo_full = 0; req_data = '0;
        tick;
        tick;
        rst = 1;
    endtask

    int w, seq, cur, gap, total;
    int lens[$];
    int gaps[$];
    bit m_busy;
    int m_owner, m_ptr, m_cnt;

    initial begin
        // reset held with every requester asking
        rst = 0; req = '1; req_last = '1; fifo_full = 0; req_data = '0;
        #1;
        for (int c = 0; c < 3; c++) begin
            settle;
            chk("rst_wr_en", 32'(wr_en), 0);
            chk("rst_ack", 32'(ack), 0);
            chk("rst_gnt", 32'(gnt), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_owner", 32'(owner), 0);
            tick;
        end
        rst = 1;
        settle;
        chk("rel_gnt_idle", 32'(gnt), 0);
        tick;
        settle;
        chk("rel_gnt", 32'(gnt), 32'h1);

        // round-robin table: single-word bursts with one bubble between them
        for (int k = 0; k < 10; k++) begin
            tbl[k].r = 4'hf; tbl[k].l = 4'hf; tbl[k].f = 0;
            tbl[k].w = k[0];
            tbl[k].g = k[0] ? 4'(1 << ((k / 2) % 4)) : 4'h0;
            tbl[k].a = tbl[k].g;
        end
        do_reset;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 8'(8'h10 + i);
        for (int k = 0; k < 10; k++) begin
            req = tbl[k].r; req_last = tbl[k].l; fifo_full = tbl[k].f;
            settle;
            chk($sformatf("rr_gnt[%0d]", k), 32'(gnt), 32'(tbl[k].g));
            chk($sformatf("rr_wr[%0d]", k), 32'(wr_en), 32'(tbl[k].w));
            chk($sformatf("rr_ack[%0d]", k), 32'(ack), 32'(tbl[k].a));
            if (tbl[k].w) chk($sformatf("rr_data[%0d]", k), 32'(wr_data), 32'(8'h10 + (k / 2) % 4));
            tick;
        end

        // burst cap: 40 words from requester 2
        do_reset;
        req = 4'b0100; seq = 1; cur = 0; gap = 0; total = 0;
        lens.delete(); gaps.delete();
        for (int c = 0; c < 200 && total < 40; c++) begin
            req_data[2*DW +: DW] = 8'(seq);
            req_last[2] = (seq == 40);
            settle;
            if (wr_en) begin
                chk("cap_data", 32'(wr_data), 32'(seq));
                if (cur == 0 && lens.size() > 0) gaps.push_back(gap);
                cur++; total++; seq++; gap = 0;
            end else begin
                if (cur > 0) lens.push_back(cur);
                cur = 0; gap++;
            end
            tick;
        end
        if (cur > 0) lens.push_back(cur);
        req = '0; req_last = '0;
        chk("cap_total", 32'(total), 40);
        chk("cap_nbursts", 32'(lens.size()), 3);
        chk("cap_len0", 32'(lens.size() > 0 ? lens[0] : 0), 16);
        chk("cap_len1", 32'(lens.size() > 1 ? lens[1] : 0), 16);
        chk("cap_len2", 32'(lens.size() > 2 ? lens[2] : 0), 8);
        chk("cap_gap0", 32'(gaps.size() > 0 ? gaps[0] : 0), 1);
        chk("cap_gap1", 32'(gaps.size() > 1 ? gaps[1] : 0), 1);
        settle;
        chk("cap_end_busy", 32'(busy), 0);
        tick;

        // full stall after word 3 of requester 1
        do_reset;
        req = 4'b0010; w = 0;
        for (int c = 0; c < 20 && w < 3; c++) begin
            req_data[DW +: DW] = 8'(w + 1);
            settle;
            if (wr_en) w++;
            tick;
        end
        chk("stall_pre", 32'(w), 3);
        fifo_full = 1; req_data[DW +: DW] = 8'(w + 1);
        for (int c = 0; c < 5; c++) begin
            settle;
            chk("stall_wr", 32'(wr_en), 0);
            chk("stall_ack", 32'(ack), 0);
            chk("stall_cnt", 32'(dut.cnt), 3);
            chk("stall_gnt", 32'(gnt), 32'h2);
            tick;
        end
        fifo_full = 0;
        settle;
        chk("resume_wr", 32'(wr_en), 1);
        chk("resume_data", 32'(wr_data), 4);
        tick;
        req_data[DW +: DW] = 8'd5;
        settle;
        chk("resume_data2", 32'(wr_data), 5);
        chk("resume_ack", 32'(ack), 32'h2);
        tick;
        req = '0;

        // abort while full
        do_reset;
        req = 4'b0011;
        tick;
        fifo_full = 1; req = 4'b0010;
        settle;
        chk("abort_wr", 32'(wr_en), 0);
        chk("abort_gnt0", 32'(gnt), 32'h1);
        tick;
        settle;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_ptr", 32'(dut.rr_ptr), 1);
        tick;
        settle;
        chk("abort_gnt1", 32'(gnt), 32'h2);
        chk("abort_owner", 32'(owner), 1);
        tick;
        fifo_full = 0; req = '0;

        // reset during word 5
        do_reset;
        req = 4'b1000; w = 0;
        for (int c = 0; c < 20 && w < 4; c++) begin
            req_data[3*DW +: DW] = 8'(w + 1);
            settle;
            if (wr_en) w++;
            tick;
        end
        req_data[3*DW +: DW] = 8'd5;
        rst = 0;
        settle;
        chk("mrst_wr", 32'(wr_en), 0);
        chk("mrst_ack", 32'(ack), 0);
        tick;
        settle;
        chk("mrst_gnt", 32'(gnt), 0);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_words", 32'(w), 4);
        rst = 1; req = '0;
        tick;

        // random traffic against the reference model
        do_reset;
        m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            logic          ew, found;
            logic [N-1:0]  eg, ea;
            logic [DW-1:0] ed;
            rst = ($urandom_range(0, 99) != 0);
            req = 4'($urandom);
            req_data = 32'($urandom);
            req_last = 4'($urandom % ((c < 1500) ? 4 : 40) == 0 ? 4'hf : 4'h0);
            fifo_full = ($urandom_range(0, 4) == 0);
            ew = rst && m_busy && req[m_owner] && !fifo_full;
            eg = m_busy ? 4'(1 << m_owner) : 4'h0;
            ea = ew ? 4'(1 << m_owner) : 4'h0;
            ed = req_data[m_owner*DW +: DW];
            settle;
            chk($sformatf("rand[%0d] {gnt,owner,busy,wr,ack,data}", c),
                {12'h0, gnt, owner, busy, wr_en, ack, wr_data},
                {12'h0, eg, 2'(m_owner), m_busy, ew, ea, ed});
            if (!rst) begin
                m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
            end else if (!m_busy) begin
                found = 0;
                for (int k = 0; k < N; k++)
                    if (!found && req[(m_ptr + k) % N]) begin
                        found = 1; m_owner = (m_ptr + k) % N; m_busy = 1; m_cnt = 0;
                    end
            end else begin
                if (ew) m_cnt++;
                if (!req[m_owner] || (ew && (req_last[m_owner] || m_cnt == MB))) begin
                    m_busy = 0; m_ptr = (m_owner + 1) % N;
                end
            end
            tick;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
